// File: rtl/debug_reg_pkg.sv
// Shared definitions for the AXI4-Lite debug register bank: byte offsets of the register map,
// AXI response codes, CTRL field positions and the handshake FSM encodings.
package debug_reg_pkg;

    localparam int OFF_ID       = 'h00;
    localparam int OFF_VER      = 'h04;
    localparam int OFF_CTRL     = 'h08;
    localparam int OFF_STICKY   = 'h0C;
    localparam int OFF_RAW      = 'h10;
    localparam int OFF_CNT      = 'h14;
    localparam int OFF_SCRATCH0 = 'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_SFT_RST_BIT = 0;

    localparam logic [2:0] WS_IDLE    = 3'd0;
    localparam logic [2:0] WS_HAVE_AW = 3'd1;
    localparam logic [2:0] WS_HAVE_W  = 3'd2;
    localparam logic [2:0] WS_COMMIT  = 3'd3;
    localparam logic [2:0] WS_RESP    = 3'd4;

    localparam logic RS_IDLE = 1'b0;
    localparam logic RS_RESP = 1'b1;

    typedef enum logic [2:0] {
        SEL_ID,
        SEL_VER,
        SEL_CTRL,
        SEL_STICKY,
        SEL_RAW,
        SEL_CNT,
        SEL_SCRATCH,
        SEL_NONE
    } reg_sel_t;

endpackage

// File: rtl/sft_rst_pulse_gen.sv
// Retriggerable soft-reset pulse: a load (re)arms the down-counter and the registered output
// stays high for exactly RST_CYCLES cycles after the most recent load.
module sft_rst_pulse_gen #(
    parameter int RST_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_sft_rst
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sft_rst;

    // Output is registered, so it looks one count ahead: it drops on the edge where r_cnt reaches 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_sft_rst <= 1'b0;
        end else if (i_load) begin
            r_cnt     <= CNT_W'(RST_CYCLES);
            r_sft_rst <= 1'b1;
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_sft_rst <= (r_cnt > CNT_W'(1));
        end
    end

    assign o_sft_rst = r_sft_rst;

endmodule

// File: rtl/debug_reg_bank.sv
// AXI4-Lite debug register bank: ID/version, W1C sticky events, raw status, soft-reset pulse
// with saturating trigger counter, and byte-strobed scratch registers.
module debug_reg_bank
    import debug_reg_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter int          N_STATUS   = 4,
    parameter int          N_SCRATCH  = 4,
    parameter logic [31:0] ID_VALUE   = 32'h0123_4567,
    parameter logic [31:0] VER_VALUE  = 32'h89ab_cdef,
    parameter int          RST_CYCLES = 16
) (
    input  logic                axi_clk,
    input  logic                axi_rst,
    input  logic                s_axi_lite_awvalid,
    input  logic [ADDR_W-1:0]   s_axi_lite_awaddr,
    output logic                s_axi_lite_awready,
    input  logic                s_axi_lite_wvalid,
    input  logic [31:0]         s_axi_lite_wdata,
    input  logic [3:0]          s_axi_lite_wstrb,
    output logic                s_axi_lite_wready,
    output logic                s_axi_lite_bvalid,
    output logic [1:0]          s_axi_lite_bresp,
    input  logic                s_axi_lite_bready,
    input  logic                s_axi_lite_arvalid,
    input  logic [ADDR_W-1:0]   s_axi_lite_araddr,
    output logic                s_axi_lite_arready,
    output logic                s_axi_lite_rvalid,
    output logic [31:0]         s_axi_lite_rdata,
    output logic [1:0]          s_axi_lite_rresp,
    input  logic                s_axi_lite_rready,
    input  logic [N_STATUS-1:0] sts_evt_i,
    input  logic [N_STATUS-1:0] sts_raw_i,
    output logic                sft_rst
);

    localparam int WIDX_W = ADDR_W - 2;
    localparam int SIDX_W = (N_SCRATCH > 1) ? $clog2(N_SCRATCH) : 1;

    logic [2:0]          r_wstate;
    logic                r_rstate;
    logic [WIDX_W-1:0]   r_awidx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rresp;
    logic [31:0]         r_rdata;
    logic [N_STATUS-1:0] r_sticky;
    logic [31:0]         r_scratch [N_SCRATCH];
    logic [31:0]         r_sft_cnt;

    logic [WIDX_W-1:0]   w_aridx;
    logic [WIDX_W-1:0]   w_rd_off;
    logic [WIDX_W-1:0]   w_wr_off;
    logic [SIDX_W-1:0]   w_rd_sidx;
    logic [SIDX_W-1:0]   w_wr_sidx;
    reg_sel_t            w_rd_sel;
    reg_sel_t            w_wr_sel;
    logic [31:0]         w_rd_data;
    logic                w_commit;
    logic                w_trigger;
    logic [N_STATUS-1:0] w_sticky_clr;
    logic                w_unused;

    function automatic reg_sel_t decode(input logic [WIDX_W-1:0] idx);
        reg_sel_t sel;
        sel = SEL_NONE;
        if (idx == WIDX_W'(OFF_ID / 4))          sel = SEL_ID;
        else if (idx == WIDX_W'(OFF_VER / 4))    sel = SEL_VER;
        else if (idx == WIDX_W'(OFF_CTRL / 4))   sel = SEL_CTRL;
        else if (idx == WIDX_W'(OFF_STICKY / 4)) sel = SEL_STICKY;
        else if (idx == WIDX_W'(OFF_RAW / 4))    sel = SEL_RAW;
        else if (idx == WIDX_W'(OFF_CNT / 4))    sel = SEL_CNT;
        else if (idx >= WIDX_W'(OFF_SCRATCH0 / 4) &&
                 idx <  WIDX_W'(OFF_SCRATCH0 / 4 + N_SCRATCH)) sel = SEL_SCRATCH;
        return sel;
    endfunction

    assign w_aridx   = s_axi_lite_araddr[ADDR_W-1:2];
    assign w_rd_sel  = decode(w_aridx);
    assign w_wr_sel  = decode(r_awidx);
    assign w_rd_off  = w_aridx - WIDX_W'(OFF_SCRATCH0 / 4);
    assign w_wr_off  = r_awidx - WIDX_W'(OFF_SCRATCH0 / 4);
    assign w_rd_sidx = w_rd_off[SIDX_W-1:0];
    assign w_wr_sidx = w_wr_off[SIDX_W-1:0];

    assign w_commit     = (r_wstate == WS_COMMIT);
    assign w_trigger    = w_commit && (w_wr_sel == SEL_CTRL) && r_wdata[CTRL_SFT_RST_BIT];
    assign w_sticky_clr = (w_commit && w_wr_sel == SEL_STICKY) ? r_wdata[N_STATUS-1:0] : '0;

    always_comb begin
        w_rd_data = '0;
        case (w_rd_sel)
            SEL_ID:      w_rd_data = ID_VALUE;
            SEL_VER:     w_rd_data = VER_VALUE;
            SEL_STICKY:  w_rd_data[N_STATUS-1:0] = r_sticky;
            SEL_RAW:     w_rd_data[N_STATUS-1:0] = sts_raw_i;
            SEL_CNT:     w_rd_data = r_sft_cnt;
            SEL_SCRATCH: w_rd_data = r_scratch[w_rd_sidx];
            default:     w_rd_data = '0;
        endcase
    end

    // Write channel: AW and W latch independently; the register commit happens in WS_COMMIT.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_wstate <= WS_IDLE;
            r_awidx  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                WS_IDLE: begin
                    if (s_axi_lite_awvalid) r_awidx <= s_axi_lite_awaddr[ADDR_W-1:2];
                    if (s_axi_lite_wvalid) begin
                        r_wdata <= s_axi_lite_wdata;
                        r_wstrb <= s_axi_lite_wstrb;
                    end
                    if (s_axi_lite_awvalid && s_axi_lite_wvalid) r_wstate <= WS_COMMIT;
                    else if (s_axi_lite_awvalid)                 r_wstate <= WS_HAVE_AW;
                    else if (s_axi_lite_wvalid)                  r_wstate <= WS_HAVE_W;
                end
                WS_HAVE_AW: begin
                    if (s_axi_lite_wvalid) begin
                        r_wdata  <= s_axi_lite_wdata;
                        r_wstrb  <= s_axi_lite_wstrb;
                        r_wstate <= WS_COMMIT;
                    end
                end
                WS_HAVE_W: begin
                    if (s_axi_lite_awvalid) begin
                        r_awidx  <= s_axi_lite_awaddr[ADDR_W-1:2];
                        r_wstate <= WS_COMMIT;
                    end
                end
                WS_COMMIT: begin
                    r_bresp  <= (w_wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                    r_wstate <= WS_RESP;
                end
                WS_RESP: begin
                    if (s_axi_lite_bready) r_wstate <= WS_IDLE;
                end
                default: r_wstate <= WS_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_rstate <= RS_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                RS_IDLE: begin
                    if (s_axi_lite_arvalid) begin
                        r_rdata  <= w_rd_data;
                        r_rresp  <= (w_rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                        r_rstate <= RS_RESP;
                    end
                end
                default: begin
                    if (s_axi_lite_rready) r_rstate <= RS_IDLE;
                end
            endcase
        end
    end

    // Event set is OR-ed in after the W1C mask so a same-cycle event survives a clear.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_sticky  <= '0;
            r_sft_cnt <= '0;
            for (int i = 0; i < N_SCRATCH; i++) r_scratch[i] <= '0;
        end else begin
            r_sticky <= (r_sticky & ~w_sticky_clr) | sts_evt_i;
            if (w_trigger && r_sft_cnt != 32'hFFFF_FFFF) r_sft_cnt <= r_sft_cnt + 32'd1;
            if (w_commit && w_wr_sel == SEL_SCRATCH) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_wstrb[b]) r_scratch[w_wr_sidx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    sft_rst_pulse_gen #(
        .RST_CYCLES (RST_CYCLES)
    ) u_pulse (
        .i_clk     (axi_clk),
        .i_rst     (axi_rst),
        .i_load    (w_trigger),
        .o_sft_rst (sft_rst)
    );

    assign s_axi_lite_awready = (r_wstate == WS_IDLE) || (r_wstate == WS_HAVE_W);
    assign s_axi_lite_wready  = (r_wstate == WS_IDLE) || (r_wstate == WS_HAVE_AW);
    assign s_axi_lite_bvalid  = (r_wstate == WS_RESP);
    assign s_axi_lite_bresp   = r_bresp;
    assign s_axi_lite_arready = (r_rstate == RS_IDLE);
    assign s_axi_lite_rvalid  = (r_rstate == RS_RESP);
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_rresp   = r_rresp;

    assign w_unused = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0], w_rd_off, w_wr_off};

endmodule
